// File: rtl/stream_demux_1_to_n.sv
// Registered 1-to-N packet demultiplexer: the first beat's select locks a channel
// until the last beat; out-of-range selects discard the whole packet and pulse err_sel.

module stream_demux_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // Fill is only issued when the slot is empty or draining, so a fill always wins.
  always_comb begin
    vld_d  = vld_q & ~ready_i;
    data_d = data_q;
    last_d = last_q;
    if (fill_i) begin
      vld_d  = 1'b1;
      data_d = data_i;
      last_d = last_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign valid_o = vld_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
endmodule

module stream_demux_1_to_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_last,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               busy,
  output logic               err_sel
);
  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_e;

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] lock_q, lock_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             sel_ok, tgt_ok, rdy_tgt, in_fire;
  logic [SEL_W-1:0] target;
  logic [N-1:0]     fill;

  assign sel_ok = ({1'b0, in_sel} < N_EXT);

  // Ready looks only at the target channel so a stalled sink never gates others.
  always_comb begin
    target  = (state_q == ROUTE) ? lock_q : in_sel;
    tgt_ok  = (state_q == ROUTE) || ((state_q == IDLE) && sel_ok);
    rdy_tgt = 1'b0;
    for (int k = 0; k < N; k++)
      if (target == SEL_W'(k)) rdy_tgt = ~out_valid[k] | out_ready[k];
    in_ready = tgt_ok ? rdy_tgt : 1'b1;
  end

  assign in_fire = in_valid & in_ready;

  always_comb begin
    fill = '0;
    for (int k = 0; k < N; k++)
      fill[k] = in_fire & tgt_ok & (target == SEL_W'(k));
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (sel_ok) begin
            if (!in_last) begin
              state_d = ROUTE;
              lock_d  = in_sel;
            end
          end else begin
            err_d = 1'b1;
            if (!in_last) state_d = DROP;
          end
        end
      end
      ROUTE, DROP: begin
        if (in_fire && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign busy    = busy_q;
  assign err_sel = err_q;

  for (genvar k = 0; k < N; k++) begin : g_ch
    stream_demux_chan #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .fill_i  (fill[k]),
      .data_i  (in_data),
      .last_i  (in_last),
      .ready_i (out_ready[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*WIDTH +: WIDTH]),
      .last_o  (out_last[k])
    );
  end
endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Directed bench for stream_demux_1_to_n: a 4-channel instance plus a 3-channel
// instance used for out-of-range select handling.

module tb_stream_demux_1_to_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  a_data;
  logic [1:0]  a_sel;
  logic        a_last, a_valid, a_ready;
  logic [31:0] a_odata;
  logic [3:0]  a_olast, a_ovalid, a_oready;
  logic        a_busy, a_err;

  logic [7:0]  b_data;
  logic [1:0]  b_sel;
  logic        b_last, b_valid, b_ready;
  logic [23:0] b_odata;
  logic [2:0]  b_olast, b_ovalid, b_oready;
  logic        b_busy, b_err;

  int total = 0;
  int bad   = 0;

  stream_demux_1_to_n #(.WIDTH(8), .N(4), .SEL_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_sel(a_sel), .in_last(a_last),
    .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata), .out_last(a_olast),
    .out_valid(a_ovalid), .out_ready(a_oready), .busy(a_busy), .err_sel(a_err)
  );

  stream_demux_1_to_n #(.WIDTH(8), .N(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_sel(b_sel), .in_last(b_last),
    .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata), .out_last(b_olast),
    .out_valid(b_ovalid), .out_ready(b_oready), .busy(b_busy), .err_sel(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    a_valid = v; a_sel = s; a_data = d; a_last = l;
  endtask

  task automatic drive_b(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    b_valid = v; b_sel = s; b_data = d; b_last = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(1'b0, 2'd0, 8'h00, 1'b0); a_oready = 4'b1111;
    drive_b(1'b0, 2'd0, 8'h00, 1'b0); b_oready = 3'b111;
    tick(); tick();
    total++; if (a_ovalid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", a_ovalid); end
    total++; if (a_odata !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", a_odata); end
    total++; if (a_olast !== 4'b0000) begin bad++; $display("FAIL reset_last got=%b exp=0000", a_olast); end
    total++; if ({a_busy, a_err} !== 2'b00) begin bad++; $display("FAIL reset_busy_err got=%b exp=00", {a_busy, a_err}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    a_oready = 4'b1111;
    drive_a(1'b1, 2'd2, 8'hA5, 1'b1);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", a_ready); end
    tick();
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    total++; if (a_ovalid !== 4'b0100) begin bad++; $display("FAIL single_valid got=%b exp=0100", a_ovalid); end
    total++; if (a_odata[16 +: 8] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", a_odata[16 +: 8]); end
    total++; if (a_olast[2] !== 1'b1) begin bad++; $display("FAIL single_last got=%b exp=1", a_olast[2]); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", a_busy); end
    tick();
    total++; if (a_ovalid !== 4'b0000) begin bad++; $display("FAIL single_drained got=%b exp=0000", a_ovalid); end
  endtask

  task automatic test_lock();
    logic [7:0] beats [3];
    logic [1:0] sels  [3];
    beats = '{8'h11, 8'h22, 8'h33};
    sels  = '{2'd1, 2'd3, 2'd3};
    a_oready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, sels[i], beats[i], i == 2);
      tick();
      total++; if (a_ovalid !== 4'b0010) begin bad++; $display("FAIL lock_valid%0d got=%b exp=0010", i, a_ovalid); end
      total++; if (a_odata[8 +: 8] !== beats[i]) begin bad++; $display("FAIL lock_data%0d got=%h exp=%h", i, a_odata[8 +: 8], beats[i]); end
      total++; if (a_olast[1] !== (i == 2)) begin bad++; $display("FAIL lock_last%0d got=%b exp=%b", i, a_olast[1], i == 2); end
      total++; if (a_busy !== (i != 2)) begin bad++; $display("FAIL lock_busy%0d got=%b exp=%b", i, a_busy, i != 2); end
    end
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    total++; if (a_ovalid !== 4'b0000) begin bad++; $display("FAIL lock_drained got=%b exp=0000", a_ovalid); end
  endtask

  task automatic test_backpressure();
    a_oready = 4'b1110;
    drive_a(1'b1, 2'd0, 8'h01, 1'b0);
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_empty got=%b exp=1", a_ready); end
    tick();
    drive_a(1'b1, 2'd2, 8'h02, 1'b1);
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", a_ready); end
    tick();
    total++; if (a_ovalid[0] !== 1'b1 || a_odata[0 +: 8] !== 8'h01) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/01", a_ovalid[0], a_odata[0 +: 8]); end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b exp=1", a_busy); end
    a_oready = 4'b1111;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_drain got=%b exp=1", a_ready); end
    tick();
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    total++; if (a_ovalid !== 4'b0001 || a_odata[0 +: 8] !== 8'h02 || a_olast[0] !== 1'b1) begin
      bad++; $display("FAIL bp_refill got=%b/%h/%b exp=0001/02/1", a_ovalid, a_odata[0 +: 8], a_olast[0]);
    end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b exp=0", a_busy); end
    tick();
    total++; if (a_ovalid !== 4'b0000) begin bad++; $display("FAIL bp_drained got=%b exp=0000", a_ovalid); end
  endtask

  task automatic test_independent();
    logic [7:0] beats [3];
    beats = '{8'hC1, 8'hC2, 8'hC3};
    a_oready = 4'b1110;
    drive_a(1'b1, 2'd0, 8'h5A, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 2'd3, beats[i], i == 2);
      #1;
      total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL ind_ready%0d got=%b exp=1", i, a_ready); end
      tick();
      total++; if (a_ovalid !== 4'b1001) begin bad++; $display("FAIL ind_valid%0d got=%b exp=1001", i, a_ovalid); end
      total++; if (a_odata[24 +: 8] !== beats[i]) begin bad++; $display("FAIL ind_data%0d got=%h exp=%h", i, a_odata[24 +: 8], beats[i]); end
      total++; if (a_odata[0 +: 8] !== 8'h5A) begin bad++; $display("FAIL ind_hold%0d got=%h exp=5a", i, a_odata[0 +: 8]); end
    end
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    tick();
    total++; if (a_ovalid !== 4'b0001) begin bad++; $display("FAIL ind_stall got=%b exp=0001", a_ovalid); end
    a_oready = 4'b1111;
    tick();
    total++; if (a_ovalid !== 4'b0000) begin bad++; $display("FAIL ind_drained got=%b exp=0000", a_ovalid); end
  endtask

  task automatic test_bad_sel();
    b_oready = 3'b111;
    drive_b(1'b1, 2'd3, 8'h77, 1'b0);
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL bad_ready0 got=%b exp=1", b_ready); end
    tick();
    total++; if (b_err !== 1'b1) begin bad++; $display("FAIL bad_err0 got=%b exp=1", b_err); end
    total++; if (b_ovalid !== 3'b000) begin bad++; $display("FAIL bad_valid0 got=%b exp=000", b_ovalid); end
    total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL bad_busy0 got=%b exp=1", b_busy); end
    drive_b(1'b1, 2'd0, 8'h78, 1'b1);
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL bad_ready1 got=%b exp=1", b_ready); end
    tick();
    total++; if (b_err !== 1'b0) begin bad++; $display("FAIL bad_err1 got=%b exp=0", b_err); end
    total++; if (b_ovalid !== 3'b000) begin bad++; $display("FAIL bad_valid1 got=%b exp=000", b_ovalid); end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL bad_busy1 got=%b exp=0", b_busy); end
    drive_b(1'b1, 2'd0, 8'h99, 1'b1);
    tick();
    drive_b(1'b0, 2'd0, 8'h00, 1'b0);
    total++; if (b_ovalid !== 3'b001 || b_odata[0 +: 8] !== 8'h99) begin bad++; $display("FAIL bad_next got=%b/%h exp=001/99", b_ovalid, b_odata[0 +: 8]); end
    total++; if (b_err !== 1'b0) begin bad++; $display("FAIL bad_err2 got=%b exp=0", b_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    a_oready = 4'b1111;
    drive_a(1'b1, 2'd2, 8'h44, 1'b0);
    tick();
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    total++; if (a_ovalid !== 4'b0100 || a_busy !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b/%b exp=0100/1", a_ovalid, a_busy); end
    rst = 1'b1;
    #1;
    total++; if (a_ovalid !== 4'b0000) begin bad++; $display("FAIL mid_async_valid got=%b exp=0000", a_ovalid); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL mid_async_busy got=%b exp=0", a_busy); end
    tick();
    rst = 1'b0;
    drive_a(1'b1, 2'd0, 8'h66, 1'b1);
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", a_ready); end
    tick();
    drive_a(1'b0, 2'd0, 8'h00, 1'b0);
    total++; if (a_ovalid !== 4'b0001 || a_odata[0 +: 8] !== 8'h66) begin bad++; $display("FAIL mid_route got=%b/%h exp=0001/66", a_ovalid, a_odata[0 +: 8]); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", a_busy); end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_lock();
    test_backpressure();
    test_independent();
    test_bad_sel();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
